// File: rtl/wb_burst_sram.sv
// wb_burst_sram
//   Wishbone B4 registered-feedback SRAM slave. Terminates classic cycles and
//   incrementing bursts (linear, wrap-4/8/16). After the first beat, burst
//   beats have no wait states. Byte-lane writes use SEL. Reserved cycle types
//   are answered with ERR.
//
// Ports
//   clk    : sole clock, all state on the rising edge
//   rstn   : asynchronous active-low reset
//   adr    : byte address; only the word index adr[ADDR_LSB +: MEM_ADDR_BITS] is used
//   cti    : cycle type identifier
//   bte    : burst type extension (00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16)
//   dat_w  : write data
//   sel    : byte-lane write enables
//   cyc    : bus cycle in progress
//   stb    : strobe
//   we     : write enable
//   dat_r  : read data, valid only while ack is high
//   ack    : beat acknowledge
//   err    : error termination for reserved cycle types
module wb_burst_sram #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WB_ADDR_WIDTH-1:0]   adr,
  input  logic [2:0]                 cti,
  input  logic [1:0]                 bte,
  input  logic [WB_DATA_WIDTH-1:0]   dat_w,
  input  logic [WB_DATA_WIDTH/8-1:0] sel,
  input  logic                       cyc,
  input  logic                       stb,
  input  logic                       we,
  output logic [WB_DATA_WIDTH-1:0]   dat_r,
  output logic                       ack,
  output logic                       err
);

  localparam int LANES    = WB_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(LANES);
  localparam int DEPTH    = 2 ** MEM_ADDR_BITS;

  typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERROR} state_t;

  state_t                     state_p1, state_nxt;
  logic [MEM_ADDR_BITS-1:0]   ptr_p1, ptr_nxt;
  logic [MEM_ADDR_BITS-1:0]   adr_idx, step_idx, rd_idx;
  logic                       req, rd_en, wr_en;
  logic [WB_DATA_WIDTH-1:0]   dat_r_p1;
  logic [WB_DATA_WIDTH-1:0]   mem [DEPTH];
  logic                       unused_adr;

  // Next burst index: bits inside the wrap window increment modulo the window
  // size, bits above it are held. Linear bursts wrap over the whole array.
  function automatic logic [MEM_ADDR_BITS-1:0] next_ptr(
    input logic [MEM_ADDR_BITS-1:0] p,
    input logic [1:0]               mode
  );
    logic [MEM_ADDR_BITS-1:0] mask;
    logic [MEM_ADDR_BITS-1:0] inc;
    case (mode)
      2'b01:   mask = MEM_ADDR_BITS'(3);
      2'b10:   mask = MEM_ADDR_BITS'(7);
      2'b11:   mask = MEM_ADDR_BITS'(15);
      default: mask = '1;
    endcase
    inc = p + MEM_ADDR_BITS'(1);
    return (p & ~mask) | (inc & mask);
  endfunction

  // Base decode happens upstream; the remaining address bits are don't-care.
  assign unused_adr = ^adr;

  assign adr_idx  = adr[ADDR_LSB +: MEM_ADDR_BITS];
  assign step_idx = next_ptr(ptr_p1, bte);
  assign req      = cyc & stb;

  always_comb begin
    state_nxt = state_p1;
    ptr_nxt   = ptr_p1;
    rd_en     = 1'b0;
    rd_idx    = adr_idx;
    wr_en     = 1'b0;
    case (state_p1)
      IDLE: begin
        if (req) begin
          ptr_nxt = adr_idx;
          rd_en   = 1'b1;
          rd_idx  = adr_idx;
          case (cti)
            3'b000, 3'b111: state_nxt = SINGLE;
            3'b010:         state_nxt = BURST;
            default:        state_nxt = ERROR;
          endcase
        end
      end
      SINGLE: begin
        // Hold the acknowledge intent through master wait cycles.
        if (!cyc) begin
          state_nxt = IDLE;
        end else if (stb) begin
          wr_en     = we;
          state_nxt = IDLE;
        end
      end
      BURST: begin
        if (!cyc) begin
          state_nxt = IDLE;
        end else if (stb) begin
          // Beat taken: write current index and prefetch the next one so the
          // following beat can be acknowledged without a wait state.
          wr_en   = we;
          ptr_nxt = step_idx;
          rd_en   = 1'b1;
          rd_idx  = step_idx;
          if (cti == 3'b111) begin
            state_nxt = IDLE;
          end
        end
      end
      ERROR: begin
        if (!cyc || stb) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: control state, burst pointer and registered read data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_p1 <= IDLE;
      ptr_p1   <= '0;
    end else begin
      state_p1 <= state_nxt;
      ptr_p1   <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dat_r_p1 <= '0;
    end else if (rd_en) begin
      dat_r_p1 <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (sel[i]) begin
          mem[ptr_p1][i*8 +: 8] <= dat_w[i*8 +: 8];
        end
      end
    end
  end

  // Registered intent gated by the live strobe; ack and err come from
  // mutually exclusive states.
  assign ack   = req & ((state_p1 == SINGLE) | (state_p1 == BURST));
  assign err   = req & (state_p1 == ERROR);
  assign dat_r = dat_r_p1;

endmodule

// File: doc/wb_burst_sram.md
# wb_burst_sram

Wishbone B4 registered-feedback SRAM slave; sits directly downstream of the interconnect slave port (`s0`) and terminates its transactions. Supports classic cycles and incrementing bursts (linear, wrap-4/8/16) with zero-wait-state beats after the first. Byte-lane writes via SEL. Reserved cycle types are answered with ERR.

## Interface
- WB_ADDR_WIDTH, 32, bus address width.
- WB_DATA_WIDTH, 32, bus data width; multiple of 8.
- MEM_ADDR_BITS, 10, word-index width; depth = 2**MEM_ADDR_BITS words.
- Derived: ADDR_LSB = $clog2(WB_DATA_WIDTH/8).
- Word index: ADR[ADDR_LSB +: MEM_ADDR_BITS]. Other ADR bits ignored; base decode belongs upstream.

- clk  in  1  sole clock; all state on rising edge.
- rstn  in  1  reset; asynchronous assert, active-low.
- s  wb_if.slave  WB_ADDR_WIDTH/WB_DATA_WIDTH  bus port.
  - Inputs: ADR, CTI[2:0], BTE[1:0], DAT_W, SEL, CYC, STB, WE.
  - Outputs: DAT_R, ACK, ERR.

## Operation
- States: IDLE, SINGLE, BURST, ERROR.
- Request: CYC&STB.
- IDLE + request, by CTI:
  - CTI = 000 or 111 -> SINGLE.
  - CTI = 010 -> BURST.
  - CTI = 001, 011-110 -> ERROR.
  - Every transition: load ptr = word index of ADR; issue read at that index.
- SINGLE:
  - ACK=1 for exactly one cycle.
  - Read: DAT_R = mem[ptr].
  - Write (WE=1): mem[ptr] bytes with SEL[i]=1 take DAT_W lane i in the ACK cycle.
  - Then IDLE; ACK=0 for at least one cycle before the next request is accepted.
- BURST:
  - Beat = cycle with CYC&STB&ACK.
  - ADR ignored after first beat; all beats use ptr.
  - Each beat: write as in SINGLE if WE; ptr <= next(ptr); read issued at next(ptr) so next beat has no wait.
  - next(ptr), by BTE:
    - 00: ptr+1 mod 2**MEM_ADDR_BITS.
    - 01: low 2 bits increment mod 4; upper bits held.
    - 10: low 3 bits mod 8.
    - 11: low 4 bits mod 16.
  - Beat with CTI=111 is last -> IDLE.
  - STB=0 while CYC=1 (master wait): ACK=0, ptr/data held; resumes same beat when STB returns.
  - CYC=0 at any point -> IDLE; no write.
- ERROR: ERR=1 one cycle, no memory access -> IDLE.
- ACK and ERR never asserted together. Both are gated by CYC&STB; the registered intent is held.
- Memory contents not reset. DAT_R is valid only when ACK=1.

## Timing
- Reset: state=IDLE, ACK=0, ERR=0, DAT_R=0, ptr=0. Reset mid-burst aborts the burst; in-flight write beat discarded.
- Latency: request in cycle N -> ACK/ERR in cycle N+1.
- Burst of L beats with no master waits: ACK high cycles N+1..N+L, low at N+L+1.
- Single: ACK high cycle N+1 only, even if STB stays high. Next request sampled at N+2 -> earliest ACK at N+3.
- Read-after-write inside a burst to the same index (wrap-4 revisit impossible within 4 beats): no forwarding required.
- Simultaneous CYC drop and CTI=111 beat: beat not taken (ACK gated off) -> IDLE.

## Test plan
- Reset: assert rstn=0 mid-burst -> ACK=0, ERR=0, DAT_R=0 immediately. After release, classic read completes normally.
- Classic: write 0xDEADBEEF @ADR 0x10, SEL=1111; then read @0x10 -> ACK one cycle after each STB, read returns 0xDEADBEEF. Partial write SEL=0010 data 0x0000AA00 -> readback 0xDEADAABE... lane1 only changed: 0xDEADAAEF.
- Linear burst: 4-beat write 0x1..0x4 @0x3FF8 (index 1022, MEM_ADDR_BITS=10), CTI 010,010,010,111 -> ACK 4 consecutive cycles. Indices 1022,1023,0,1 hold 1..4.
- Wrap-4: read burst BTE=01 starting index 6, 4 beats -> data from indices 6,7,4,5, zero waits.
- Wait/abort: STB low 2 cycles mid-burst -> ACK low, same beat resumes. CYC drop mid-burst -> IDLE, no further writes.
- Reserved CTI=011 write -> ERR one cycle, ACK=0, memory unchanged.
